// File: rtl/noc_params.sv
// noc_params: router-wide port count, port encoding and credit depth
package noc_params;
  localparam int PORT_NUM = 5;
  localparam int PORT_W = $clog2(PORT_NUM);
  localparam int CREDIT_DEPTH = 8;
  typedef enum logic [PORT_W-1:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
endpackage

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: one-hot round-robin grant, pointer advances past the winner only on a grant
module round_robin_arbiter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] gnt
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] ptr, idx, j;
  logic [W:0]   s;
  logic         found;
  // scan req starting at ptr, wrapping modulo N
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    s = '0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (W+1)'(k);
      j = s >= (W+1)'(N) ? W'(s - (W+1)'(N)) : s[W-1:0];
      if (enable && !found && req[j]) begin
        found = 1'b1;
        idx = j;
        gnt[j] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (found) ptr <= idx == W'(N - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/switch_allocator_rr.sv
// switch_allocator_rr: per-output round-robin switch allocation gated by downstream credits,
// with registered crossbar selects for the switch-traversal stage
module switch_allocator_rr
  import noc_params::port_t;
#(
  parameter int PORT_NUM = noc_params::PORT_NUM,
  parameter int CREDIT_DEPTH = noc_params::CREDIT_DEPTH,
  localparam int SEL_W = $clog2(PORT_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORT_NUM-1:0] switch_request,
  input  port_t               out_port [PORT_NUM],
  input  logic [PORT_NUM-1:0] credit_in,
  output logic [PORT_NUM-1:0] valid_sel,
  output logic [SEL_W-1:0]    xbar_sel [PORT_NUM],
  output logic [PORT_NUM-1:0] xbar_valid
);
  localparam int CW = $clog2(CREDIT_DEPTH + 1);
  logic [PORT_NUM-1:0] req [PORT_NUM];
  logic [PORT_NUM-1:0] gnt [PORT_NUM];
  logic [SEL_W-1:0]    enc [PORT_NUM];
  logic [CW-1:0]       credit [PORT_NUM];
  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    // out-of-range out_port values never match any output
    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
      assign req[o][i] = switch_request[i] && out_port[i] == SEL_W'(o);
    end
    round_robin_arbiter #(.N(PORT_NUM)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req[o]),
      .enable (rst && credit[o] != '0),
      .gnt    (gnt[o])
    );
    assert property (@(posedge clk) disable iff (!rst)
      !(credit_in[o] && !(|gnt[o]) && credit[o] == CW'(CREDIT_DEPTH)))
      else $error("credit_in on full output %0d", o);
  end
  always_comb begin
    valid_sel = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      valid_sel |= gnt[o];
      enc[o] = '0;
      for (int i = 0; i < PORT_NUM; i++) enc[o] = gnt[o][i] ? SEL_W'(i) : enc[o];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        credit[o] <= CW'(CREDIT_DEPTH);
        xbar_sel[o] <= '0;
      end
      xbar_valid <= '0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        xbar_valid[o] <= |gnt[o];
        if (|gnt[o]) xbar_sel[o] <= enc[o];
        if (|gnt[o] && !credit_in[o]) credit[o] <= credit[o] - 1'b1;
        else if (credit_in[o] && !(|gnt[o]) && credit[o] != CW'(CREDIT_DEPTH)) credit[o] <= credit[o] + 1'b1;
      end
    end
endmodule

// File: tb/tb_switch_allocator_rr.sv
// tb_switch_allocator_rr: directed vectors; expected crossbar transfers queued, monitor compares
module tb_switch_allocator_rr;
  import noc_params::*;
  typedef struct {int out; int sel;} exp_t;
  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [PORT_NUM-1:0] switch_request = '0;
  logic [PORT_NUM-1:0] credit_in = '0;
  logic [PORT_NUM-1:0] valid_sel, xbar_valid;
  port_t               out_port [PORT_NUM];
  logic [PORT_W-1:0]   xbar_sel [PORT_NUM];
  exp_t                exp_q [$];
  exp_t                e;
  int                  n_cmp = 0;
  int                  n_bad = 0;

  always #5 clk = ~clk;

  switch_allocator_rr dut (
    .clk            (clk),
    .rst            (rst),
    .switch_request (switch_request),
    .out_port       (out_port),
    .credit_in      (credit_in),
    .valid_sel      (valid_sel),
    .xbar_sel       (xbar_sel),
    .xbar_valid     (xbar_valid)
  );

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, need %0d", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int o, int s);
    exp_q.push_back('{out: o, sel: s});
  endtask

  always @(negedge clk)
    if (rst)
      for (int o = 0; o < PORT_NUM; o++)
        if (xbar_valid[o]) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL xbar_extra: out %0d sel %0d, need no transfer", o, xbar_sel[o]);
          end else begin
            e = exp_q.pop_front();
            if (e.out != o || e.sel != int'(xbar_sel[o])) begin
              n_bad++;
              $display("FAIL xbar: out %0d sel %0d, need out %0d sel %0d", o, xbar_sel[o], e.out, e.sel);
            end
          end
        end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running, need finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ord [7];
    ord = '{0, 1, 3, 4, 0, 1, 3};
    foreach (out_port[i]) out_port[i] = LOCAL;
    // reset held with requests active
    switch_request = '1;
    @(posedge clk);
    #2;
    chk("rst_valid_sel", valid_sel, 0);
    chk("rst_xbar_valid", xbar_valid, 0);
    cyc();
    chk("rst_valid_sel_2", valid_sel, 0);
    switch_request = '0;
    rst = 1'b1;
    #1;
    for (int o = 0; o < PORT_NUM; o++) chk($sformatf("credit_init[%0d]", o), dut.credit[o], 8);
    // single request
    cyc();
    switch_request[2] = 1'b1;
    out_port[2] = EAST;
    #1;
    chk("single_valid_sel", valid_sel, 5'b00100);
    push(EAST, 2);
    cyc();
    switch_request = '0;
    chk("single_credit_east", dut.credit[EAST], 7);
    // fairness on NORTH with credits returned every cycle
    switch_request = 5'b01011;
    out_port[0] = NORTH;
    out_port[1] = NORTH;
    out_port[3] = NORTH;
    credit_in[NORTH] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) begin
        switch_request[4] = 1'b1;
        out_port[4] = NORTH;
      end
      #1;
      chk($sformatf("fair_valid_sel_%0d", k), valid_sel, 1 << ord[k]);
      push(NORTH, ord[k]);
      cyc();
    end
    switch_request = '0;
    credit_in = '0;
    chk("fair_credit_north", dut.credit[NORTH], 8);
    // out-of-range target is ignored
    switch_request[0] = 1'b1;
    out_port[0] = port_t'(6);
    #1;
    chk("oor_valid_sel", valid_sel, 0);
    cyc();
    switch_request = '0;
    chk("oor_xbar_valid", xbar_valid, 0);
    // credit stall on LOCAL
    switch_request[1] = 1'b1;
    out_port[1] = LOCAL;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("stall_grant_%0d", k), valid_sel, 5'b00010);
      push(LOCAL, 1);
      cyc();
    end
    #1;
    chk("stall_valid_sel", valid_sel, 0);
    chk("stall_credit_local", dut.credit[LOCAL], 0);
    credit_in[LOCAL] = 1'b1;
    cyc();
    credit_in = '0;
    #1;
    chk("resume_valid_sel", valid_sel, 5'b00010);
    push(LOCAL, 1);
    cyc();
    switch_request = '0;
    chk("resume_credit_local", dut.credit[LOCAL], 0);
    // grant and credit return together on WEST
    switch_request[3] = 1'b1;
    out_port[3] = WEST;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("west_grant_%0d", k), valid_sel, 5'b01000);
      push(WEST, 3);
      cyc();
    end
    chk("west_credit_pre", dut.credit[WEST], 3);
    credit_in[WEST] = 1'b1;
    #1;
    chk("west_both_valid_sel", valid_sel, 5'b01000);
    push(WEST, 3);
    cyc();
    switch_request = '0;
    credit_in = '0;
    chk("west_credit_post", dut.credit[WEST], 3);
    // parallel grants to all outputs, then async reset mid-burst
    credit_in[LOCAL] = 1'b1;
    cyc();
    credit_in = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      switch_request[i] = 1'b1;
      out_port[i] = port_t'(i);
    end
    #1;
    chk("par_valid_sel", valid_sel, 5'b11111);
    cyc();
    switch_request = '0;
    chk("par_xbar_valid", xbar_valid, 5'b11111);
    for (int o = 0; o < PORT_NUM; o++) chk($sformatf("par_xbar_sel[%0d]", o), xbar_sel[o], o);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_xbar_valid", xbar_valid, 0);
    chk("mid_rst_credit_east", dut.credit[EAST], 8);
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
